// File: rtl/jtag_ir_unit.sv
`default_nettype none
// ============================================================================
//  Module      : jtag_ir_unit
//  Description : JTAG instruction register with capture/shift/update path,
//                latched opcode and a registered one-hot instruction decoder
//                driven from a configurable opcode table.
//  Option      : JTAG_IR_PRIVATE_LOCK_EN - when defined, instructions flagged
//                in PRIVATE_MASK decode as the fallback instruction unless
//                UNLOCK is high at the update edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module jtag_ir_unit #(
  parameter int IR_WIDTH      = 4,
  parameter int NUM_INSTR     = 8,
  parameter logic [NUM_INSTR*IR_WIDTH-1:0] INSTR_CODES =
    {4'h5, 4'h4, 4'h8, 4'h3, 4'h2, 4'h1, 4'hF, 4'h7},
  parameter int RESET_INDEX   = 0,
  parameter int DEFAULT_INDEX = 1,
  parameter logic [NUM_INSTR-1:0] PRIVATE_MASK = '0
) (
  input  logic                  TCK,
  input  logic                  RST,
  input  logic                  TDI,
  input  logic                  TLR,
  input  logic                  CAPTURE_IR,
  input  logic                  SHIFT_IR,
  input  logic                  UPDATE_IR,
  input  logic [IR_WIDTH-3:0]   IR_STATUS,
  input  logic                  UNLOCK,
  output logic                  TDO_IR,
  output logic [IR_WIDTH-1:0]   LATCH_JTAG_IR,
  output logic [NUM_INSTR-1:0]  INSTR_SELECT,
  output logic                  BYPASS_SELECT,
  output logic                  IR_UPDATED
);

  // Fixed IEEE 1149.1 capture pattern in the two LSBs.
  localparam logic [1:0] c_capture_lsbs = 2'b01;

  // Shift register contents after reset.
  localparam logic [IR_WIDTH-1:0] c_sr_reset =
    {{(IR_WIDTH-2){1'b0}}, c_capture_lsbs};

  // Opcode and select vector restored by reset or Test-Logic-Reset.
  localparam logic [IR_WIDTH-1:0] c_reset_code =
    INSTR_CODES[RESET_INDEX*IR_WIDTH +: IR_WIDTH];

  localparam logic [NUM_INSTR-1:0] c_reset_sel =
    {{(NUM_INSTR-1){1'b0}}, 1'b1} << RESET_INDEX;

  // Selected state and next state.
  logic [IR_WIDTH-1:0]  sr_q;
  logic [IR_WIDTH-1:0]  sr_d;
  logic [IR_WIDTH-1:0]  latch_q;
  logic [IR_WIDTH-1:0]  latch_d;
  logic [NUM_INSTR-1:0] sel_q;
  logic [NUM_INSTR-1:0] sel_d;
  logic                 upd_q;
  logic                 upd_d;

  // Decoder results.
  logic [NUM_INSTR-1:0] w_allow;
  logic [NUM_INSTR-1:0] w_dec_sel;
  logic                 w_dec_hit;

  // Per-instruction permission: private entries need UNLOCK when the lock
  // feature is compiled in; otherwise every entry is decodable.
`ifdef JTAG_IR_PRIVATE_LOCK_EN
  assign w_allow = ~PRIVATE_MASK | {NUM_INSTR{UNLOCK}};
`else
  assign w_allow = {NUM_INSTR{1'b1}};

  // UNLOCK and PRIVATE_MASK have no function in this build.
  logic w_unused_lock;
  assign w_unused_lock = ^{UNLOCK, PRIVATE_MASK};
`endif

  // Decode the shift register: lowest matching permitted index wins, no hit
  // falls back to DEFAULT_INDEX, so the result is always exactly one-hot.
  always_comb begin
    w_dec_sel = '0;
    w_dec_hit = 1'b0;
    for (int i = 0; i < NUM_INSTR; i++) begin
      if (!w_dec_hit && w_allow[i] &&
          (sr_q == INSTR_CODES[i*IR_WIDTH +: IR_WIDTH])) begin
        w_dec_sel[i] = 1'b1;
        w_dec_hit    = 1'b1;
      end
    end
    if (!w_dec_hit) begin
      w_dec_sel[DEFAULT_INDEX] = 1'b1;
    end
  end

  // Next-state selection with strobe priority TLR > UPDATE > CAPTURE > SHIFT.
  // The latched opcode and selects only move on TLR or Update-IR, so the
  // previous instruction stays active throughout capture and shift.
  always_comb begin
    sr_d    = sr_q;
    latch_d = latch_q;
    sel_d   = sel_q;
    upd_d   = 1'b0;
    if (TLR) begin
      latch_d = c_reset_code;
      sel_d   = c_reset_sel;
      upd_d   = 1'b1;
    end else if (UPDATE_IR) begin
      latch_d = sr_q;
      sel_d   = w_dec_sel;
      upd_d   = 1'b1;
    end else if (CAPTURE_IR) begin
      sr_d    = {IR_STATUS, c_capture_lsbs};
    end else if (SHIFT_IR) begin
      sr_d    = {TDI, sr_q[IR_WIDTH-1:1]};
    end
  end

  // State registers with synchronous reset taking priority over all strobes.
  always_ff @(posedge TCK) begin
    if (RST) begin
      sr_q    <= c_sr_reset;
      latch_q <= c_reset_code;
      sel_q   <= c_reset_sel;
      upd_q   <= 1'b0;
    end else begin
      sr_q    <= sr_d;
      latch_q <= latch_d;
      sel_q   <= sel_d;
      upd_q   <= upd_d;
    end
  end

  // Serial out is the raw shift LSB; everything else comes from registers.
  assign TDO_IR        = sr_q[0];
  assign LATCH_JTAG_IR = latch_q;
  assign INSTR_SELECT  = sel_q;
  assign BYPASS_SELECT = sel_q[DEFAULT_INDEX];
  assign IR_UPDATED    = upd_q;

endmodule
`default_nettype wire

// File: doc/jtag_ir_unit.md
Name: jtag_ir_unit

Overview:
- Parametrised JTAG instruction register (IR) with a registered instruction decoder.
- Implements the IR capture, shift and update path, the latched instruction, and a one-hot select vector built from a configurable opcode table.
- Sits between the TAP controller state outputs and the data-register multiplexer.
- Unknown opcodes map to a configurable fallback instruction.

Parameters:
- IR_WIDTH, 4: instruction length in bits; must be 3 or more.
- NUM_INSTR, 8: number of decoded instructions, i.e. the width of INSTR_SELECT.
- INSTR_CODES, {4'h5,4'h4,4'h8,4'h3,4'h2,4'h1,4'hF,4'h7}: packed opcode table, IR_WIDTH bits per entry, entry 0 in the LSBs.
  - Default order, index 0..7: IDCODE, BYPASS, SAMPLE, EXTEST, INTEST, USERCODE, RUNBIST, GETTEST.
- RESET_INDEX, 0: instruction selected after reset or Test-Logic-Reset (IDCODE).
- DEFAULT_INDEX, 1: instruction selected for an opcode not in the table (BYPASS).
- PRIVATE_MASK, 8'h00: NUM_INSTR bits; bit i set marks instruction i as private. Used only with the optional feature.

Ports:
- TCK  in  1  JTAG test clock; all state changes on its rising edge.
- RST  in  1  synchronous reset, active-high.
- TDI  in  1  serial data in.
- TLR  in  1  TAP is in Test-Logic-Reset.
- CAPTURE_IR  in  1  TAP is in Capture-IR.
- SHIFT_IR  in  1  TAP is in Shift-IR.
- UPDATE_IR  in  1  TAP is in Update-IR.
- IR_STATUS  in  IR_WIDTH-2  status bits loaded on capture.
- UNLOCK  in  1  private-instruction enable (optional feature only).
- TDO_IR  out  1  serial out; equals shift-register bit 0.
- LATCH_JTAG_IR  out  IR_WIDTH  currently active opcode.
- INSTR_SELECT  out  NUM_INSTR  one-hot active instruction.
- BYPASS_SELECT  out  1  equals INSTR_SELECT[DEFAULT_INDEX].
- IR_UPDATED  out  1  one-cycle pulse after a new instruction takes effect.

Interface decision:
- One clock; reset is synchronous and active-high.
- Clock port is TCK, reset port is RST.

Behaviour:
- Reset (RST=1 at an edge):
  - shift register = {0…0, 2'b01}
  - LATCH_JTAG_IR = INSTR_CODES[RESET_INDEX]
  - INSTR_SELECT = 1 << RESET_INDEX
  - IR_UPDATED = 0
- Control priority per edge: RST > TLR > UPDATE_IR > CAPTURE_IR > SHIFT_IR > hold.
  - A legal TAP asserts at most one of these strobes; simultaneous assertion is resolved by this priority, never X.
- TLR: same as reset for LATCH_JTAG_IR and INSTR_SELECT, and IR_UPDATED = 1 the next cycle. The shift register is left unchanged.
- CAPTURE_IR: shift register <= {IR_STATUS, 2'b01}, per IEEE 1149.1 LSB pattern.
- SHIFT_IR: shift register <= {TDI, sr[IR_WIDTH-1:1]}; LSB first out.
  - TDO_IR is a combinational copy of sr[0], with no extra register.
  - Shifting more than IR_WIDTH bits simply discards the oldest bits.
- UPDATE_IR, single edge:
  - LATCH_JTAG_IR <= sr.
  - INSTR_SELECT <= decode(sr), registered on the same edge, so latch and selects are always consistent.
  - IR_UPDATED is high for exactly the following cycle.
- Decode:
  - Compare sr with every table entry. If the table has duplicate codes, the lowest index wins.
  - No match selects DEFAULT_INDEX.
  - Result is always exactly one-hot; all-zero is never produced.
- LATCH_JTAG_IR and INSTR_SELECT hold during capture and shift, so the previous instruction stays active until Update-IR.
- Reset mid-shift: partial shift contents are discarded; the next shift starts from the reset pattern.

Optional Feature:
- Macro: JTAG_IR_PRIVATE_LOCK_EN.
- Defined:
  - An opcode matching a PRIVATE_MASK instruction while UNLOCK=0 at the update edge decodes as DEFAULT_INDEX.
  - LATCH_JTAG_IR still records the shifted opcode.
  - Deasserting UNLOCK later does not revoke an already-active instruction.
- Undefined: the UNLOCK port exists but is ignored; PRIVATE_MASK has no effect.

Test Plan:
- Reset then idle 3 cycles -> LATCH_JTAG_IR=4'h7, INSTR_SELECT=8'h01, TDO_IR=1, IR_UPDATED=0.
- Capture with IR_STATUS=2'b10, then shift TDI 0,1,0,0 (LSB first), then update -> TDO sequence 1,0,0,1; LATCH_JTAG_IR=4'h2, INSTR_SELECT=8'h08 (EXTEST), IR_UPDATED high for 1 cycle.
- Shift and update 4'hA (not in table) -> LATCH_JTAG_IR=4'hA, INSTR_SELECT=8'h02, BYPASS_SELECT=1.
- Load 4'h8, then TLR for 1 cycle -> LATCH_JTAG_IR=4'h7, INSTR_SELECT=8'h01, IR_UPDATED pulses.
- RST asserted halfway through shifting 4'h3, then a new capture/shift/update of 4'h1 -> INSTR_SELECT=8'h04 (SAMPLE), no residue from the aborted shift.
- With JTAG_IR_PRIVATE_LOCK_EN and PRIVATE_MASK=8'h40:
  - update 4'h4 with UNLOCK=0 -> INSTR_SELECT=8'h02;
  - update 4'h4 with UNLOCK=1 -> INSTR_SELECT=8'h40.
